// File: rtl/control_types_pkg.sv
// rtl/control_types_pkg.sv - shared state encoding and constants for pipeline hazard control
package control_types_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_DWAIT    = 2'd1,
        ST_IDISCARD = 2'd2
    } hazard_state_t;

    localparam logic [4:0] REG_ZERO_IDX = 5'd0;

    // The unused encoding 3 behaves as ST_RUN.
    function automatic hazard_state_t sanitize_state(input logic [1:0] raw);
        case (raw)
            2'd1:    return ST_DWAIT;
            2'd2:    return ST_IDISCARD;
            default: return ST_RUN;
        endcase
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational load-use dependency detector between EX and ID
module load_use_detect
    import control_types_pkg::*;
(
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rd_idx,
    input  logic [4:0] id_rs1_idx,
    input  logic [4:0] id_rs2_idx,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    output logic       load_use
);

    logic rs1_hit;
    logic rs2_hit;

    always_comb begin
        rs1_hit  = id_uses_rs1 && (id_rs1_idx == ex_rd_idx);
        rs2_hit  = id_uses_rs2 && (id_rs2_idx == ex_rd_idx);
        // x0 is never written, so a load targeting it cannot create a dependency.
        load_use = ex_mem_read && (ex_rd_idx != REG_ZERO_IDX) && (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush scheduler for the 5-stage pipeline (optional HAZARD_PERF_CNT_EN)
module pipeline_hazard_ctrl
    import control_types_pkg::*;
#(
    parameter int DMEM_TIMEOUT = 64,
    parameter int CNT_W        = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1_idx,
    input  logic [4:0]  id_rs2_idx,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd_idx,
    input  logic        ex_branch_taken,
    input  logic        imem_ready,
    input  logic        dmem_req,
    input  logic        dmem_ready,
    output logic        pc_enable,
    output logic        if_id_enable,
    output logic        id_ex_enable,
    output logic        ex_mem_enable,
    output logic        mem_wb_enable,
    output logic        if_id_clear,
    output logic        id_ex_clear,
    output logic        ex_mem_clear,
    output logic        mem_wb_clear,
    output logic        mem_fault,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_flush_count,
`endif
    output logic [1:0]  ctrl_state
);

    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(DMEM_TIMEOUT);

    hazard_state_t    state_q, state_d;
    hazard_state_t    resume_q, resume_d;
    hazard_state_t    base_state;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fault_q, fault_d;
    logic             load_use;
    logic             dstall;
    logic             branch_honoured;

    load_use_detect u_load_use_detect (
        .ex_mem_read (ex_mem_read),
        .ex_rd_idx   (ex_rd_idx),
        .id_rs1_idx  (id_rs1_idx),
        .id_rs2_idx  (id_rs2_idx),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .load_use    (load_use)
    );

    always_comb begin
        pc_enable       = 1'b1;
        if_id_enable    = 1'b1;
        id_ex_enable    = 1'b1;
        ex_mem_enable   = 1'b1;
        mem_wb_enable   = 1'b1;
        if_id_clear     = 1'b0;
        id_ex_clear     = 1'b0;
        ex_mem_clear    = 1'b0;
        mem_wb_clear    = 1'b0;
        branch_honoured = 1'b0;
        dstall          = dmem_req && !dmem_ready;

        // While waiting on data memory the remembered pre-stall state governs.
        base_state = (sanitize_state(state_q) == ST_DWAIT) ? sanitize_state(resume_q)
                                                            : sanitize_state(state_q);
        state_d  = base_state;
        resume_d = resume_q;
        cnt_d    = '0;
        fault_d  = fault_q;

        if (dstall) begin
            pc_enable     = 1'b0;
            if_id_enable  = 1'b0;
            id_ex_enable  = 1'b0;
            ex_mem_enable = 1'b0;
            mem_wb_clear  = 1'b1;
            state_d       = ST_DWAIT;
            resume_d      = base_state;
            cnt_d         = (cnt_q >= TIMEOUT_VAL) ? cnt_q : cnt_q + CNT_W'(1);
            if (cnt_d >= TIMEOUT_VAL) begin
                fault_d = 1'b1;
            end
        end else if (ex_branch_taken) begin
            branch_honoured = 1'b1;
            pc_enable       = 1'b1;
            if_id_clear     = 1'b1;
            id_ex_clear     = 1'b1;
            state_d         = imem_ready ? ST_RUN : ST_IDISCARD;
        end else if (base_state == ST_IDISCARD) begin
            pc_enable = 1'b0;
            if (load_use) begin
                if_id_enable = 1'b0;
                id_ex_clear  = 1'b1;
            end else begin
                if_id_clear = 1'b1;
            end
            // The fetch that finally lands belongs to the abandoned path.
            if (imem_ready) begin
                if_id_clear = 1'b1;
                state_d     = ST_RUN;
            end
        end else if (load_use) begin
            pc_enable    = 1'b0;
            if_id_enable = 1'b0;
            id_ex_clear  = 1'b1;
        end else if (!imem_ready) begin
            pc_enable   = 1'b0;
            if_id_clear = 1'b1;
        end

        if (rst) begin
            pc_enable       = 1'b0;
            if_id_enable    = 1'b0;
            id_ex_enable    = 1'b0;
            ex_mem_enable   = 1'b0;
            mem_wb_enable   = 1'b0;
            if_id_clear     = 1'b1;
            id_ex_clear     = 1'b1;
            ex_mem_clear    = 1'b1;
            mem_wb_clear    = 1'b1;
            branch_honoured = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            resume_q <= ST_RUN;
            cnt_q    <= '0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            resume_q <= resume_d;
            cnt_q    <= cnt_d;
            fault_q  <= fault_d;
        end
    end

    assign mem_fault  = fault_q;
    assign ctrl_state = state_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_flush_q, perf_flush_d;

    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_flush_d = perf_flush_q;
        if (!pc_enable) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
        if (branch_honoured) begin
            perf_flush_d = perf_flush_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_stall_cycles = perf_stall_q;
    assign perf_flush_count  = perf_flush_q;
`endif

endmodule
